// File: rtl/apb_pkg.sv
// Shared types and widths for the two-requester APB arbiter.
package apb_pkg;

    localparam int PROT_W = 3;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// One APB link. The requester side uses the master modport; the arbiter
// receives requests through the slave modport and drives downstream
// through the master modport.
interface apb_rr_arbiter_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic [PROT_W-1:0] pprot;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to whichever requester was not served last.
module apb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    // Pure combinational pick; the caller registers the result.
    always_comb begin
        any     = |req;
        gnt_idx = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB path between the
// instruction-fetch (m0) and load/store (m1) masters. Each granted
// transfer gets a fresh SETUP/ACCESS sequence downstream, and an optional
// timeout forces an error completion on a hung slave.
//
//   state  | meaning
//   IDLE   | no transfer downstream; arbitrate pending requests
//   SETUP  | out_psel=1, out_penable=0 for the granted requester
//   ACCESS | out_psel=1, out_penable=1; wait for out_pready or timeout
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    apb_rr_arbiter_if.slave   m0,
    apb_rr_arbiter_if.slave   m1,
    apb_rr_arbiter_if.master  out
);

    // Last ACCESS cycle index before a forced completion; unused when
    // the timeout is disabled.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_idx;
    logic              pick_any;
    logic              busy;
    logic              forced;
    logic              complete;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mux_paddr;
    logic [DATA_W-1:0] mux_pwdata;

    apb_rr_pick u_pick (
        .req     ({m1.psel, m0.psel}),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // State register; reset makes m0 win the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Completion qualifiers: a real pready always wins over the timeout.
    always_comb begin
        busy      = (state_q != IDLE);
        forced    = (TIMEOUT != 0) && (state_q == ACCESS) && !out.pready && (cnt_q == TO_LAST);
        complete  = (state_q == ACCESS) && (out.pready || forced);
        rsp_rdata = forced ? '0 : out.prdata;
        rsp_err   = forced ? 1'b1 : out.pslverr;
    end

    // Next-state: arbitrate in IDLE, hold the grant through the transfer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (complete) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Downstream request: forward the granted requester, zero when idle.
    always_comb begin
        mux_paddr   = grant_q ? m1.paddr : m0.paddr;
        mux_pwdata  = grant_q ? m1.pwdata : m0.pwdata;
        out.psel    = busy;
        out.penable = (state_q == ACCESS);
        out.paddr   = '0;
        out.pprot   = '0;
        out.pwrite  = 1'b0;
        out.pwdata  = '0;
        out.pstrb   = '0;
        if (busy) begin
            out.paddr  = mux_paddr;
            out.pprot  = grant_q ? m1.pprot : m0.pprot;
            out.pwrite = grant_q ? m1.pwrite : m0.pwrite;
            out.pwdata = mux_pwdata;
            out.pstrb  = grant_q ? m1.pstrb : m0.pstrb;
        end
    end

    // Response routing: only the granted requester, only on completion.
    // A requester that dropped penable mid-transfer gets nothing.
    always_comb begin
        m0.pready  = 1'b0;
        m0.prdata  = '0;
        m0.pslverr = 1'b0;
        m1.pready  = 1'b0;
        m1.prdata  = '0;
        m1.pslverr = 1'b0;
        if (complete && !grant_q && m0.penable) begin
            m0.pready  = 1'b1;
            m0.prdata  = rsp_rdata;
            m0.pslverr = rsp_err;
        end
        if (complete && grant_q && m1.penable) begin
            m1.pready  = 1'b1;
            m1.prdata  = rsp_rdata;
            m1.pslverr = rsp_err;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: requester tasks issue transfers and
// push the expected completion into a scoreboard; a monitor pops and
// compares whenever a requester sees pready.
`timescale 1ns/1ps
module tb_apb_rr_arbiter;

    localparam int TO    = 8;
    localparam int LIMIT = 60;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    apb_rr_arbiter_if m0_if ();
    apb_rr_arbiter_if m1_if ();
    apb_rr_arbiter_if out_if ();

    apb_rr_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO),
        .CNT_W   (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .out   (out_if)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  strb;
        logic        wr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] slv_rdata = 32'h0;
    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    logic        slv_never = 1'b0;
    int          acc_n     = 0;
    int          n0, n1, nd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] prot_of(input int idx);
        return (idx == 0) ? 3'b100 : 3'b010;
    endfunction

    function automatic logic pready_of(input int idx);
        return (idx == 0) ? m0_if.pready : m1_if.pready;
    endfunction

    task automatic drive(input int idx, input logic sel, input logic en, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input logic wr);
        if (idx == 0) begin
            m0_if.psel = sel; m0_if.penable = en; m0_if.paddr = a;
            m0_if.pwdata = wd; m0_if.pstrb = st; m0_if.pwrite = wr;
            m0_if.pprot = sel ? prot_of(0) : 3'b000;
        end else begin
            m1_if.psel = sel; m1_if.penable = en; m1_if.paddr = a;
            m1_if.pwdata = wd; m1_if.pstrb = st; m1_if.pwrite = wr;
            m1_if.pprot = sel ? prot_of(1) : 3'b000;
        end
    endtask

    // One APB transfer from requester idx; n = negedges from SETUP-cycle
    // onward until pready (2 for a zero-wait slave). Aborts on reset.
    task automatic m_xfer(input int idx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic wr, output int n);
        logic done;
        done = 1'b0;
        n    = 0;
        drive(idx, 1'b1, 1'b0, a, wd, st, wr);
        @(posedge clock); #1;
        drive(idx, 1'b1, 1'b1, a, wd, st, wr);
        while (!done && n < LIMIT) begin
            @(negedge clock);
            n++;
            if (!reset) done = 1'b1;
            else if (pready_of(idx)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL m%0d_wait: no pready after %0d cycles, want <= %0d", idx, n, LIMIT);
        end
        @(posedge clock); #1;
        drive(idx, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic push(input int idx, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic wr, input logic [31:0] rd, input logic er);
        exp_t e;
        e.idx = idx; e.addr = a; e.wdata = wd; e.strb = st; e.wr = wr; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Downstream slave model: pready after slv_wait ACCESS cycles.
    initial begin
        out_if.pready  = 1'b0;
        out_if.prdata  = 32'h0;
        out_if.pslverr = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (out_if.psel && out_if.penable) acc_n++;
            else acc_n = 0;
            out_if.pready  = (acc_n > 0) && !slv_never && (acc_n > slv_wait);
            out_if.prdata  = (acc_n > 0) ? slv_rdata : 32'h0;
            out_if.pslverr = (acc_n > 0) && slv_err;
        end
    end

    // Monitor: downstream fields against the in-flight entry, responses
    // against the popped entry, idle requesters against zero.
    initial begin
        exp_t e;
        int   who;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (out_if.psel) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_psel: got out_psel=1 want no transfer at %0t", $time);
                    end else begin
                        check("out_paddr",  out_if.paddr, sb[0].addr);
                        check("out_pwdata", out_if.pwdata, sb[0].wdata);
                        check("out_pstrb",  32'(out_if.pstrb), 32'(sb[0].strb));
                        check("out_pwrite", 32'(out_if.pwrite), 32'(sb[0].wr));
                        check("out_pprot",  32'(out_if.pprot), 32'(prot_of(sb[0].idx)));
                    end
                end else begin
                    check("idle_paddr_pwdata", out_if.paddr | out_if.pwdata, 32'h0);
                    check("idle_penable", 32'(out_if.penable), 32'h0);
                end
                if (m0_if.pready && m1_if.pready) begin
                    checks++; errors++;
                    $display("FAIL double_pready: got both pready=1 want one at %0t", $time);
                end else if (m0_if.pready || m1_if.pready) begin
                    who = m1_if.pready ? 1 : 0;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pready: got m%0d pready want none at %0t", who, $time);
                    end else begin
                        e = sb.pop_front();
                        check("grant_order", 32'(who), 32'(e.idx));
                        check("rsp_prdata", (who == 0) ? m0_if.prdata : m1_if.prdata, e.rdata);
                        check("rsp_pslverr", 32'((who == 0) ? m0_if.pslverr : m1_if.pslverr), 32'(e.err));
                        check("other_rsp_zero", (who == 0) ? (m1_if.prdata | 32'(m1_if.pslverr))
                                                           : (m0_if.prdata | 32'(m0_if.pslverr)), 32'h0);
                    end
                end else begin
                    check("quiet_rsp_zero", m0_if.prdata | m1_if.prdata
                          | 32'(m0_if.pslverr) | 32'(m1_if.pslverr), 32'h0);
                end
            end
        end
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Reset state, with m0 requesting while reset is held.
        repeat (2) @(posedge clock);
        #1;
        drive(0, 1'b1, 1'b0, 32'h1234_0000, 32'h5555_5555, 4'hF, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_psel",    32'(out_if.psel), 32'h0);
        check("rst_out_penable", 32'(out_if.penable), 32'h0);
        check("rst_out_paddr",   out_if.paddr, 32'h0);
        check("rst_out_pwdata",  out_if.pwdata, 32'h0);
        check("rst_m0_pready",   32'(m0_if.pready), 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Single zero-wait read from m0.
        slv_rdata = 32'hDEAD_BEEF; slv_wait = 0; slv_err = 1'b0; slv_never = 1'b0;
        push(0, 32'h1000_0004, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        m_xfer(0, 32'h1000_0004, 32'h0, 4'h0, 1'b0, n0);
        check("single_latency", 32'(n0), 32'd2);

        // Tie right after reset: m0 first, m1 after one IDLE cycle.
        do_reset();
        slv_rdata = 32'h0000_A5A5;
        push(0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0000_A5A5, 1'b0);
        push(1, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 32'h0000_A5A5, 1'b0);
        fork
            m_xfer(0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, n0);
            m_xfer(1, 32'h0000_0200, 32'h0, 4'h0, 1'b0, n1);
        join
        check("tie_m0_latency", 32'(n0), 32'd2);
        check("tie_m1_latency", 32'(n1), 32'd5);

        // Four wait states ending with a slave error, m1 write.
        slv_rdata = 32'hCAFE_0001; slv_wait = 4; slv_err = 1'b1;
        push(1, 32'h4000_0010, 32'h5555_AAAA, 4'b0110, 1'b1, 32'hCAFE_0001, 1'b1);
        m_xfer(1, 32'h4000_0010, 32'h5555_AAAA, 4'b0110, 1'b1, n1);
        check("wait_latency", 32'(n1), 32'd6);

        // Dead slave: forced error completion in the 8th ACCESS cycle.
        slv_rdata = 32'h1234_5678; slv_wait = 0; slv_err = 1'b0; slv_never = 1'b1;
        push(0, 32'h6000_0000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
        m_xfer(0, 32'h6000_0000, 32'h0, 4'h0, 1'b0, n0);
        check("timeout_latency", 32'(n0), 32'd9);
        check("timeout_idle_psel", 32'(out_if.psel), 32'h0);
        slv_never = 1'b0;

        // Sustained contention: six writes each, strict alternation.
        do_reset();
        slv_rdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            push(0, 32'h2000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(1 << (i % 4)), 1'b1, 32'h0, 1'b0);
            push(1, 32'h3000_0000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hC, 1'b1, 32'h0, 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 6; i++)
                    m_xfer(0, 32'h2000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(1 << (i % 4)), 1'b1, n0);
            end
            begin
                for (int j = 0; j < 6; j++)
                    m_xfer(1, 32'h3000_0000 + 32'(4 * j), 32'hB000_0000 + 32'(j), 4'hC, 1'b1, n1);
            end
        join
        check("contention_drained", 32'(sb.size()), 32'h0);

        // Reset asserted mid-ACCESS drops the downstream bus immediately.
        slv_never = 1'b1;
        push(0, 32'h5000_0000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        fork
            m_xfer(0, 32'h5000_0000, 32'h0, 4'h0, 1'b0, nd);
            begin
                repeat (3) @(negedge clock);
                #2;
                check("pre_reset_access", 32'({out_if.psel, out_if.penable}), 32'h3);
                reset = 1'b0;
                #1;
                check("async_rst_psel",    32'(out_if.psel), 32'h0);
                check("async_rst_penable", 32'(out_if.penable), 32'h0);
                sb.delete();
            end
        join
        slv_never = 1'b0;
        slv_rdata = 32'h0000_0077;
        @(posedge clock); #1;
        reset = 1'b1;
        push(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h0000_0077, 1'b0);
        push(1, 32'h0000_0400, 32'h0, 4'h0, 1'b0, 32'h0000_0077, 1'b0);
        fork
            m_xfer(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, n0);
            m_xfer(1, 32'h0000_0400, 32'h0, 4'h0, 1'b0, n1);
        join
        check("post_rst_m0_latency", 32'(n0), 32'd2);
        check("post_rst_m1_latency", 32'(n1), 32'd5);

        repeat (2) @(posedge clock);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Two-requester APB arbiter that shares one downstream APB slave path (apb_delayer plus the peripheral crossbar) between the instruction-fetch master (m0) and the load/store master (m1).
- Uses round-robin grant. A grant is held for a whole transfer, and the arbiter generates a fresh SETUP/ACCESS sequence downstream for each transfer.
- An optional access timeout ends a hung transfer with an error response, so one dead peripheral cannot stall the core.

Parameters:
- ADDR_W, 32, address width of all paddr ports
- DATA_W, 32, data width of all pwdata/prdata ports
- TIMEOUT, 0, maximum number of ACCESS cycles before a forced error completion; 0 disables the timeout
- CNT_W, 16, width of the timeout counter; TIMEOUT must be less than 2^CNT_W

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- m0_paddr / m1_paddr  input  ADDR_W  requester address
- m0_psel / m1_psel  input  1  transfer request
- m0_penable / m1_penable  input  1  requester access phase
- m0_pprot / m1_pprot  input  3  protection
- m0_pwrite / m1_pwrite  input  1  write flag
- m0_pwdata / m1_pwdata  input  DATA_W  write data
- m0_pstrb / m1_pstrb  input  4  byte strobes
- m0_pready / m1_pready  output  1  completion to requester
- m0_prdata / m1_prdata  output  DATA_W  read data to requester
- m0_pslverr / m1_pslverr  output  1  error to requester
- out_paddr, out_pprot, out_pwrite, out_pwdata, out_pstrb  output  per the m-side widths  forwarded from the granted requester
- out_psel  output  1  downstream select
- out_penable  output  1  downstream access phase
- out_pready  input  1  downstream ready
- out_prdata  input  DATA_W  downstream read data
- out_pslverr  input  1  downstream error

Behaviour:
- Registered state: state in {IDLE, SETUP, ACCESS}, grant (0 = m0, 1 = m1), last (last requester served), cnt (CNT_W bits).
- Reset values: state=IDLE, grant=0, last=1 (so m0 wins the first tie), cnt=0.
- Reset is asynchronous; asserting it mid-transfer aborts immediately. All outputs are 0 while reset is asserted.
- IDLE:
  - If any mX_psel is high: grant the requester when only one requests; grant !last when both request. Go to SETUP, cnt <= 0.
  - Otherwise stay in IDLE.
- SETUP: out_psel=1, out_penable=0. Always go to ACCESS on the next cycle.
- ACCESS: out_psel=1, out_penable=1.
  - If out_pready: complete, set last <= grant, go to IDLE.
  - Else if TIMEOUT != 0 and cnt == TIMEOUT-1: forced completion, set last <= grant, go to IDLE.
  - Else cnt <= cnt + 1.
- out_psel and out_penable are 0 in IDLE.
- out_paddr, out_pprot, out_pwrite, out_pwdata, out_pstrb mux from the granted requester in SETUP/ACCESS. They are 0 in IDLE.
- The granted requester must hold its signals stable (APB rule), so the mux needs no latch.
- Completion to the granted requester:
  - mG_pready = (state==ACCESS) and (out_pready or forced) and mG_penable.
  - mG_prdata = out_prdata on normal completion, 0 on forced completion.
  - mG_pslverr = out_pslverr on normal completion, 1 on forced completion.
- The non-granted requester sees pready=0, prdata=0, pslverr=0 and simply waits.
- Minimum latency: request seen in IDLE at cycle t, SETUP at t+1, ACCESS at t+2. With a zero-wait slave, pready is returned at t+2, so a transfer completes in 3 cycles.
- Back-to-back: after a completion the arbiter spends one IDLE cycle before the next SETUP, so out_psel drops for at least one cycle between transfers. apb_delayer needs this to return to its idle state.
- If the granted requester drops psel mid-transfer (protocol violation), the transfer still runs to completion and the result is discarded.
- On a forced completion out_psel drops while the slave may still be busy. This is a documented error path; software must reset the peripheral.
- Fairness: with both requesters continuously asserting, grants alternate m0, m1, m0, …

Decomposition:
- Shared package apb_pkg:
  - state enum encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10
  - localparams for APB widths (PROT_W=3, STRB_W=4)
- One sub-module, apb_rr_pick: combinational two-way round-robin picker (inputs req[1:0] and last; outputs gnt_idx and any).
- Everything else stays in the top.

Test Plan:
- Single read, zero-wait slave: m0_psel with paddr=0x1000_0004 and slave prdata=0xDEADBEEF → out SETUP at t+1, ACCESS at t+2; m0_pready=1 with m0_prdata=0xDEADBEEF at t+2; m1 outputs stay 0.
- Simultaneous request right after reset: m0 and m1 raise psel in the same cycle → m0 is served first. m1 gets SETUP one cycle after m0 completes plus one IDLE cycle; the following tie goes to m1.
- Wait states: slave holds pready low for 4 ACCESS cycles, then pready=1 with pslverr=1 → m1_pready=1 and m1_pslverr=1 only on that cycle; out_paddr stays constant throughout.
- Timeout, TIMEOUT=8: slave never ready → in the 8th ACCESS cycle m0_pready=1, m0_pslverr=1, m0_prdata=0; IDLE on the next cycle with out_psel=0.
- Sustained contention: both requesters issue 6 write transfers each → the grant order strictly alternates, and out_pwdata/out_pstrb always match the granted requester.
- Reset mid-ACCESS: reset driven to 0 during ACCESS → out_psel and out_penable fall to 0 without waiting for a clock edge. After release, the first tie is granted to m0.
